// File: rtl/ldpc_framer_ctrl.sv
// Configuration and acquisition sequencer for the LDPC frame synchronizer.
// Owns framer code/threshold inputs, resets the framer on config change, and auto-searches code configs.
module ldpc_framer_ctrl #(
    parameter int unsigned APPLY_CYCLES = 4,
    parameter int unsigned DWELL_W      = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clkEn,
    input  logic                cfgWrite,
    input  logic                cfgAutoDetect,
    input  logic                cfgCodeLength4096,
    input  logic [1:0]          cfgCodeRate,
    input  logic signed [10:0]  cfgAcqThreshold,
    input  logic signed [10:0]  cfgTrkThreshold,
    input  logic [DWELL_W-1:0]  cfgDwellBits,
    input  logic                framerFrameSync,
    output logic                framerReset,
    output logic                codeLength4096,
    output logic [1:0]          codeRate,
    output logic signed [10:0]  syncThreshold,
    output logic                locked,
    output logic [2:0]          searchIndex,
    output logic                lockLost,
    output logic                searchTimeout
);

    localparam int unsigned THR_W   = 11;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned APPLY_W = (APPLY_CYCLES > 1) ? $clog2(APPLY_CYCLES) : 1;

    localparam logic [1:0] LDPC_RATE_1_2 = 2'd0;
    localparam logic [1:0] LDPC_RATE_2_3 = 2'd1;
    localparam logic [1:0] LDPC_RATE_4_5 = 2'd2;

    localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(5);
    localparam logic [IDX_W-1:0]        LONG_BASE  = IDX_W'(3);
    localparam logic [APPLY_W-1:0]      APPLY_LAST = APPLY_W'(APPLY_CYCLES - 1);
    localparam logic signed [THR_W-1:0] ACQ_RST    = THR_W'(48);
    localparam logic signed [THR_W-1:0] TRK_RST    = THR_W'(32);
    localparam logic [DWELL_W-1:0]      DWELL_RST  = DWELL_W'(32'h0001_0000);

    typedef enum logic [1:0] {
        ST_APPLY  = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t state, state_next;

    logic [APPLY_W-1:0]      apply_cnt, apply_cnt_next;
    logic [DWELL_W-1:0]      dwell_cnt, dwell_cnt_next;
    logic                    auto_mode, auto_mode_next;
    logic [IDX_W-1:0]        manual_idx, manual_idx_next;
    logic signed [THR_W-1:0] acq_thr, acq_thr_next;
    logic signed [THR_W-1:0] trk_thr, trk_thr_next;
    logic [DWELL_W-1:0]      dwell_len, dwell_len_next;
    logic [IDX_W-1:0]        index_next;
    logic                    expire;

    logic                    framer_reset_next;
    logic                    code_len_next;
    logic [1:0]              code_rate_next;
    logic signed [THR_W-1:0] threshold_next;
    logic                    locked_next;
    logic                    lock_lost_next;
    logic                    timeout_next;

    // Reserved rate encoding folds onto rate 1/2.
    function automatic logic [IDX_W-1:0] manual_index(input logic len4096, input logic [1:0] rate);
        logic [IDX_W-1:0] ofs;
        case (rate)
            LDPC_RATE_2_3: ofs = IDX_W'(1);
            LDPC_RATE_4_5: ofs = IDX_W'(2);
            default:       ofs = IDX_W'(0);
        endcase
        return (len4096 ? LONG_BASE : IDX_W'(0)) + ofs;
    endfunction

    assign expire = (state == ST_SEARCH) && clkEn && (dwell_len != '0)
                    && (dwell_cnt == dwell_len - DWELL_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_APPLY;
        end else begin
            state <= state_next;
        end
    end

    // Next state: cfgWrite beats frame sync, which beats dwell expiry.
    always_comb begin
        state_next = state;
        if (cfgWrite) begin
            state_next = ST_APPLY;
        end else begin
            case (state)
                ST_APPLY:  if (apply_cnt == APPLY_LAST) state_next = ST_SEARCH;
                ST_SEARCH: begin
                    if (framerFrameSync)        state_next = ST_LOCKED;
                    else if (expire && auto_mode) state_next = ST_APPLY;
                end
                ST_LOCKED: if (!framerFrameSync) state_next = ST_SEARCH;
                default:   state_next = ST_APPLY;
            endcase
        end
    end

    // Next values for counters, latched config and the registered outputs.
    always_comb begin
        apply_cnt_next  = '0;
        dwell_cnt_next  = '0;
        auto_mode_next  = auto_mode;
        manual_idx_next = manual_idx;
        acq_thr_next    = acq_thr;
        trk_thr_next    = trk_thr;
        dwell_len_next  = dwell_len;
        index_next      = searchIndex;
        lock_lost_next  = 1'b0;
        timeout_next    = 1'b0;

        if (state == ST_APPLY && !cfgWrite) begin
            apply_cnt_next = apply_cnt + APPLY_W'(1);
        end

        if (state == ST_SEARCH) begin
            if (expire)     dwell_cnt_next = '0;
            else if (clkEn) dwell_cnt_next = dwell_cnt + DWELL_W'(1);
            else            dwell_cnt_next = dwell_cnt;
        end

        if (cfgWrite) begin
            auto_mode_next  = cfgAutoDetect;
            manual_idx_next = manual_index(cfgCodeLength4096, cfgCodeRate);
            acq_thr_next    = cfgAcqThreshold;
            trk_thr_next    = cfgTrkThreshold;
            dwell_len_next  = cfgDwellBits;
            index_next      = cfgAutoDetect ? IDX_W'(0) : manual_index(cfgCodeLength4096, cfgCodeRate);
        end else if (state == ST_SEARCH && !framerFrameSync && expire) begin
            timeout_next = 1'b1;
            if (auto_mode) begin
                index_next = (searchIndex == LAST_IDX) ? IDX_W'(0) : searchIndex + IDX_W'(1);
            end
        end else if (state == ST_LOCKED && !framerFrameSync) begin
            lock_lost_next = 1'b1;
        end

        framer_reset_next = (state_next == ST_APPLY);
        locked_next       = (state_next == ST_LOCKED);
        threshold_next    = locked_next ? trk_thr_next : acq_thr_next;
        code_len_next     = (index_next >= LONG_BASE);
        code_rate_next    = code_len_next ? 2'(index_next - LONG_BASE) : index_next[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            apply_cnt      <= '0;
            dwell_cnt      <= '0;
            auto_mode      <= 1'b0;
            manual_idx     <= '0;
            acq_thr        <= ACQ_RST;
            trk_thr        <= TRK_RST;
            dwell_len      <= DWELL_RST;
            framerReset    <= 1'b1;
            codeLength4096 <= 1'b0;
            codeRate       <= LDPC_RATE_1_2;
            syncThreshold  <= ACQ_RST;
            locked         <= 1'b0;
            searchIndex    <= '0;
            lockLost       <= 1'b0;
            searchTimeout  <= 1'b0;
        end else begin
            apply_cnt      <= apply_cnt_next;
            dwell_cnt      <= dwell_cnt_next;
            auto_mode      <= auto_mode_next;
            manual_idx     <= manual_idx_next;
            acq_thr        <= acq_thr_next;
            trk_thr        <= trk_thr_next;
            dwell_len      <= dwell_len_next;
            framerReset    <= framer_reset_next;
            codeLength4096 <= code_len_next;
            codeRate       <= code_rate_next;
            syncThreshold  <= threshold_next;
            locked         <= locked_next;
            searchIndex    <= index_next;
            lockLost       <= lock_lost_next;
            searchTimeout  <= timeout_next;
        end
    end

endmodule

// File: tb/tb_ldpc_framer_ctrl.sv
// Randomized self-checking bench for ldpc_framer_ctrl against a behavioural sequencer model.
module tb_ldpc_framer_ctrl;

    localparam int unsigned APPLY_CYCLES = 4;
    localparam int unsigned DWELL_W      = 24;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                clkEn = 1'b0;
    logic                cfgWrite = 1'b0;
    logic                cfgAutoDetect = 1'b0;
    logic                cfgCodeLength4096 = 1'b0;
    logic [1:0]          cfgCodeRate = 2'd0;
    logic signed [10:0]  cfgAcqThreshold = 11'sd0;
    logic signed [10:0]  cfgTrkThreshold = 11'sd0;
    logic [DWELL_W-1:0]  cfgDwellBits = '0;
    logic                framerFrameSync = 1'b0;
    logic                framerReset;
    logic                codeLength4096;
    logic [1:0]          codeRate;
    logic signed [10:0]  syncThreshold;
    logic                locked;
    logic [2:0]          searchIndex;
    logic                lockLost;
    logic                searchTimeout;

    ldpc_framer_ctrl #(.APPLY_CYCLES(APPLY_CYCLES), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .reset(reset), .clkEn(clkEn), .cfgWrite(cfgWrite),
        .cfgAutoDetect(cfgAutoDetect), .cfgCodeLength4096(cfgCodeLength4096),
        .cfgCodeRate(cfgCodeRate), .cfgAcqThreshold(cfgAcqThreshold),
        .cfgTrkThreshold(cfgTrkThreshold), .cfgDwellBits(cfgDwellBits),
        .framerFrameSync(framerFrameSync), .framerReset(framerReset),
        .codeLength4096(codeLength4096), .codeRate(codeRate),
        .syncThreshold(syncThreshold), .locked(locked), .searchIndex(searchIndex),
        .lockLost(lockLost), .searchTimeout(searchTimeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: what the sequencer is doing, in terms of phases and remaining counts.
    bit m_auto, m_applying, m_locked, m_lost, m_to;
    int m_man_len, m_man_rate, m_acq, m_trk, m_dwell, m_idx, m_left, m_bits;
    int rate_ofs [4] = '{0, 1, 2, 0};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic enter_apply();
        m_applying = 1;
        m_locked   = 0;
        m_left     = APPLY_CYCLES;
    endtask

    task automatic model_step();
        m_lost = 0;
        m_to   = 0;
        if (reset) begin
            m_auto = 0; m_acq = 48; m_trk = 32; m_dwell = 65536; m_idx = 0; m_bits = 0;
            enter_apply();
        end else if (cfgWrite) begin
            m_auto  = cfgAutoDetect;
            m_acq   = int'(cfgAcqThreshold);
            m_trk   = int'(cfgTrkThreshold);
            m_dwell = int'(cfgDwellBits);
            m_idx   = m_auto ? 0 : (cfgCodeLength4096 ? 3 : 0) + rate_ofs[cfgCodeRate];
            enter_apply();
        end else if (m_applying) begin
            m_left--;
            if (m_left == 0) begin
                m_applying = 0;
                m_bits     = 0;
            end
        end else if (m_locked) begin
            if (!framerFrameSync) begin
                m_locked = 0;
                m_lost   = 1;
                m_bits   = 0;
            end
        end else if (framerFrameSync) begin
            m_locked = 1;
        end else if (clkEn) begin
            m_bits++;
            if (m_dwell != 0 && m_bits == m_dwell) begin
                m_to   = 1;
                m_bits = 0;
                if (m_auto) begin
                    m_idx = (m_idx + 1) % 6;
                    enter_apply();
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("framerReset",    int'(framerReset),    int'(m_applying));
        chk("locked",         int'(locked),         int'(m_locked));
        chk("searchIndex",    int'(searchIndex),    m_idx);
        chk("codeLength4096", int'(codeLength4096), m_idx / 3);
        chk("codeRate",       int'(codeRate),       m_idx % 3);
        chk("syncThreshold",  int'(syncThreshold),  m_locked ? m_trk : m_acq);
        chk("lockLost",       int'(lockLost),       int'(m_lost));
        chk("searchTimeout",  int'(searchTimeout),  int'(m_to));
    endtask

    // One clock: advance the model with the current inputs, then compare after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic write_cfg(input bit auto_mode, input bit len, input logic [1:0] rate,
                             input int acq, input int trk, input int dwell);
        cfgAutoDetect     = auto_mode;
        cfgCodeLength4096 = len;
        cfgCodeRate       = rate;
        cfgAcqThreshold   = 11'(acq);
        cfgTrkThreshold   = 11'(trk);
        cfgDwellBits      = DWELL_W'(dwell);
        cfgWrite          = 1'b1;
        cycle();
        cfgWrite          = 1'b0;
    endtask

    task automatic wait_apply_done(input string name);
        int n = 0;
        while (framerReset && n < 50) begin
            cycle();
            n++;
        end
        if (framerReset) chk({name, "_timeout"}, 1, 0);
    endtask

    initial begin
        int n, tos, last_to, found;
        int seq_exp [6] = '{1, 2, 3, 4, 5, 0};

        // Reset and apply window after reset.
        reset = 1'b1;
        cycle();
        cycle();
        chk("rst_framerReset_lit", int'(framerReset), 1);
        chk("rst_threshold_lit", int'(syncThreshold), 48);
        reset = 1'b0;
        n = 0;
        while (framerReset && n < 20) begin
            n++;
            cycle();
        end
        chk("rst_apply_len_lit", n, 4);
        chk("rst_index_lit", int'(searchIndex), 0);

        // Auto search with dwell 100 and no sync.
        clkEn = 1'b1;
        write_cfg(1, 0, 2'd2, -100, 200, 100);
        chk("auto_index_lit", int'(searchIndex), 0);
        tos = 0; last_to = 0; n = 0;
        while (tos < 6 && n < 1000) begin
            cycle();
            n++;
            if (searchTimeout) begin
                chk("auto_seq_lit", int'(searchIndex), seq_exp[tos]);
                if (tos > 0) chk("auto_gap_lit", n - last_to, 104);
                last_to = n;
                tos++;
            end
        end
        chk("auto_timeouts_lit", tos, 6);

        // Lock on index 4.
        found = 0; n = 0;
        while (!found && n < 2000) begin
            clkEn = 1'($urandom_range(0, 1));
            cycle();
            n++;
            if (searchIndex == 3'd4 && !framerReset) found = 1;
        end
        chk("wait_idx4", found, 1);
        framerFrameSync = 1'b1;
        cycle();
        chk("lock_locked_lit", int'(locked), 1);
        chk("lock_thr_lit", int'(syncThreshold), 200);
        chk("lock_len_lit", int'(codeLength4096), 1);
        chk("lock_rate_lit", int'(codeRate), 1);
        tos = 0;
        for (int i = 0; i < 300; i++) begin
            clkEn = 1'b1;
            cycle();
            tos += int'(searchTimeout);
        end
        chk("locked_no_timeout_lit", tos, 0);

        // Lock loss.
        framerFrameSync = 1'b0;
        cycle();
        chk("loss_pulse_lit", int'(lockLost), 1);
        chk("loss_thr_lit", int'(syncThreshold), -100);
        chk("loss_idx_lit", int'(searchIndex), 4);
        chk("loss_noreset_lit", int'(framerReset), 0);
        cycle();
        chk("loss_pulse_end_lit", int'(lockLost), 0);

        // Manual mode, dwell 0, then reserved rates.
        write_cfg(0, 0, 2'd2, 60, 20, 0);
        chk("man_idx_lit", int'(searchIndex), 2);
        tos = 0;
        for (int i = 0; i < 400; i++) begin
            clkEn = 1'($urandom_range(0, 1));
            cycle();
            tos += int'(searchTimeout);
        end
        chk("man_no_timeout_lit", tos, 0);
        write_cfg(0, 0, 2'd3, 60, 20, 0);
        chk("reserved_idx_lit", int'(searchIndex), 0);
        write_cfg(0, 1, 2'd3, 60, 20, 0);
        chk("reserved_long_idx_lit", int'(searchIndex), 3);

        // Manual expiry with dwell 5 keeps searching without framer reset.
        clkEn = 1'b1;
        write_cfg(0, 1, 2'd1, 10, 300, 5);
        wait_apply_done("man5");
        for (int i = 0; i < 5; i++) cycle();
        chk("man_expiry_lit", int'(searchTimeout), 1);
        chk("man_expiry_noreset_lit", int'(framerReset), 0);
        chk("man_expiry_idx_lit", int'(searchIndex), 4);

        // Lock coinciding with expiry: lock wins.
        write_cfg(0, 1, 2'd1, 10, 300, 5);
        wait_apply_done("coinc");
        for (int i = 0; i < 4; i++) cycle();
        framerFrameSync = 1'b1;
        cycle();
        chk("coinc_locked_lit", int'(locked), 1);
        chk("coinc_no_timeout_lit", int'(searchTimeout), 0);

        // cfgWrite coinciding with held lock goes to apply.
        write_cfg(0, 0, 2'd1, 10, 300, 5);
        chk("cfg_lock_apply_lit", int'(framerReset), 1);
        chk("cfg_lock_unlocked_lit", int'(locked), 0);
        wait_apply_done("relock");
        cycle();
        chk("relock_lit", int'(locked), 1);

        // Reset while locked.
        reset = 1'b1;
        cycle();
        chk("rst_locked_lit", int'(locked), 0);
        chk("rst_locked_thr_lit", int'(syncThreshold), 48);
        chk("rst_locked_freset_lit", int'(framerReset), 1);
        reset = 1'b0;
        framerFrameSync = 1'b0;

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            clkEn           = ($urandom_range(0, 99) < 60);
            reset           = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 19) == 0) framerFrameSync = ~framerFrameSync;
            cfgWrite        = ($urandom_range(0, 149) == 0);
            if (cfgWrite) begin
                cfgAutoDetect     = 1'($urandom_range(0, 1));
                cfgCodeLength4096 = 1'($urandom_range(0, 1));
                cfgCodeRate       = 2'($urandom_range(0, 3));
                cfgAcqThreshold   = 11'($urandom);
                cfgTrkThreshold   = 11'($urandom);
                cfgDwellBits      = DWELL_W'($urandom_range(0, 30));
            end
            cycle();
        end
        cfgWrite = 1'b0;
        reset    = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldpc_framer_ctrl.md
# ldpc_framer_ctrl

Configuration and acquisition sequencer for the LDPC frame synchronizer. It owns the framer's code-length, code-rate and sync-threshold inputs, and holds the framer in reset whenever configuration changes. It applies a loose acquisition threshold while hunting and a tight tracking threshold once locked. In auto-detect mode it steps through all six LDPC code configurations until the framer reports frame sync. It sits between the register interface and the framer in the demod bit path.

## Interface

Parameters
- `APPLY_CYCLES`, default 4: number of clk cycles `framerReset` is held after any configuration change.
- `DWELL_W`, default 24: width of the dwell counter and of `cfgDwellBits`.

Ports
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `clkEn` in 1: bit-rate enable, shared with the framer.
- `cfgWrite` in 1: one-cycle pulse; latches all `cfg*` inputs.
- `cfgAutoDetect` in 1: 1 = search all configurations; 0 = manual.
- `cfgCodeLength4096` in 1: manual code length.
- `cfgCodeRate` in 2: manual rate, using the `LDPC_RATE_*` encodings.
- `cfgAcqThreshold` in 11, signed: threshold used while not locked.
- `cfgTrkThreshold` in 11, signed: threshold used while locked.
- `cfgDwellBits` in `DWELL_W`: number of clkEn bits per search attempt; 0 disables the timeout.
- `framerFrameSync` in 1: framer `frameSync` output.
- `framerReset` out 1: drives the framer reset input.
- `codeLength4096` out 1: to the framer.
- `codeRate` out 2: to the framer.
- `syncThreshold` out 11, signed: to the framer.
- `locked` out 1: high in the LOCKED state.
- `searchIndex` out 3: active configuration index, 0–5.
- `lockLost` out 1: one-cycle pulse.
- `searchTimeout` out 1: one-cycle pulse.

## Operation

**Configuration index map**
- 0: 2048, rate 1/2
- 1: 2048, rate 2/3
- 2: 2048, rate 4/5
- 3: 4096, rate 1/2
- 4: 4096, rate 2/3
- 5: 4096, rate 4/5
- In manual mode the index is `{cfgCodeLength4096 ? 3 : 0} + rate offset`. A reserved rate encoding maps to rate 1/2.
- `codeLength4096` and `codeRate` are registered decodes of `searchIndex`.

**Latched config registers and reset values**
- Auto-detect = 0, manual index = 0, acquisition threshold = 48, tracking threshold = 32, dwell = 0x010000.

**State machine**
- APPLY
  - `framerReset` = 1 and a cycle counter runs on clk (not clkEn-gated).
  - After `APPLY_CYCLES` cycles: clear the dwell counter and go to SEARCH.
- SEARCH
  - `syncThreshold` = acquisition threshold.
  - The dwell counter increments on clkEn.
  - `framerFrameSync` = 1 → LOCKED.
  - Dwell expiry: on the clkEn cycle where count == dwell−1 with dwell ≠ 0, pulse `searchTimeout`.
  - Expiry in auto mode: `searchIndex` advances (5 wraps to 0), then go to APPLY.
  - Expiry in manual mode: clear the counter and stay in SEARCH; the framer is not reset.
- LOCKED
  - `syncThreshold` = tracking threshold, `locked` = 1.
  - `framerFrameSync` = 0 → pulse `lockLost`, clear the dwell counter, go to SEARCH with the same index and no framer reset.

**Priority when events coincide**
- `cfgWrite` > `framerFrameSync` > dwell expiry.
- `cfgWrite` in any state: latch the config and go to APPLY.
  - Auto mode: `searchIndex` restarts at 0.
  - Manual mode: `searchIndex` = manual index.
- Lock and expiry on the same cycle: lock wins and no `searchTimeout` pulse is produced.

**Threshold path**
- `syncThreshold` is registered and switches on the cycle after the state change.
- Thresholds pass through unmodified.

## Timing

**Reset values (during `reset` and in the cycle after it)**
- State = APPLY, `framerReset` = 1, `searchIndex` = 0, `codeLength4096` = 0, `codeRate` = `LDPC_RATE_1_2`.
- `syncThreshold` = 48, `locked` = 0, `lockLost` = 0, `searchTimeout` = 0.

**Latencies**
- After `reset` deasserts, `framerReset` stays high for exactly `APPLY_CYCLES` clk cycles.
- `cfgWrite` at cycle N gives:
  - new `codeRate` / `codeLength4096` and `framerReset` = 1 at N+1;
  - `framerReset` low at N+1+`APPLY_CYCLES`.
- A `cfgWrite` during APPLY restarts the APPLY count.
- `framerFrameSync` rising at N gives `locked` = 1 and the tracking threshold at N+1.
- `framerFrameSync` falling at N gives `lockLost` high for the single cycle N+1 and the acquisition threshold at N+1.

**Gating**
- The dwell counter only advances on clkEn. APPLY does not depend on clkEn.
- `framerFrameSync` is ignored during APPLY.

**Counter width**
- The dwell counter is `DWELL_W` bits wide with no overflow, because it is compared against `cfgDwellBits`−1.

## Test plan

- Reset, then hold `reset` low → `framerReset` high for 4 cycles, `searchIndex` = 0, `syncThreshold` = 48, all pulses low.
- Auto mode with dwell = 100 and no sync → `searchTimeout` every 100 clkEn bits. `searchIndex` steps 0,1,2,3,4,5,0, with a 4-cycle `framerReset` after each step.
- Auto mode, `framerFrameSync` asserted during index 4 → `locked` = 1, `syncThreshold` = tracking threshold, `codeLength4096` = 1, rate = 2/3, no further timeouts.
- Locked, then `framerFrameSync` drops → one-cycle `lockLost`, SEARCH state with index unchanged, no `framerReset`, acquisition threshold restored.
- Manual mode, 2048 length, rate 4/5, dwell = 0 → index 2, no `searchTimeout` ever. A reserved rate written in manual mode gives index 0.
- Same-cycle cases:
  - `cfgWrite` coinciding with lock gives APPLY.
  - Lock coinciding with dwell expiry gives LOCKED with no timeout pulse.
  - `reset` asserted while LOCKED gives all reset values on the next cycle.
